branch_predictor_nway: RTL and testbench

//  Parametrised successor to the fetch-stage bimodal predictor + BTB: LANES-wide lookup per fetch group,

---
 rtl/branch_predictor_nway_pkg.sv | 28 ++
 rtl/branch_predictor_nway_if.sv | 41 ++++
 rtl/bp_sat_counter.sv | 38 +++
 rtl/branch_predictor_nway.sv | 140 ++++++++++++++
 tb/tb_branch_predictor_nway.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_nway_pkg.sv
// branch_predictor_nway_pkg
//   Shared definitions for the N-lane bimodal/gshare predictor + BTB:
//   PC field macros, predictor state encoding and counter init helper.
//   Optional feature macro used by the top: GSHARE_HASH_EN.
// Ports: none (package).

`ifndef BRANCH_PREDICTOR_NWAY_DEFS
`define BRANCH_PREDICTOR_NWAY_DEFS
// Word-aligned PC fields: index sits directly above the byte offset, tag above the index.
`define IDX_RANGE(ab) (ab)+1:2
`define TAG_RANGE(ab) 31:(ab)+2
`endif

package branch_predictor_nway_pkg;

    typedef enum logic {
        StClear = 1'b0,
        StReady = 1'b1
    } bp_state_e;

    localparam int unsigned CntMaxBits = 4;

    // Weakly not-taken: just below the MSB-set threshold.
    function automatic int unsigned counter_init(input int unsigned cbits);
        return (32'd1 << (cbits - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_nway_if.sv
// branch_predictor_nway_if
//   Fetch / resolve bus of the predictor.
//   master: drives fetch (we_i, pc_i) and resolution updates, reads predictions.
//   slave : the predictor itself.
// Signals:
//   we_i, pc_i                   fetch advance and next fetch PC
//   update_i, update_pc_i,
//   update_tgt_i, update_taken_i,
//   update_is_br_i               resolved control-flow update
//   ready_o                      low during table-clear sweep
//   hit_o, pred_o                per-lane BTB hit and taken prediction
//   tgt_o                        per-lane target, lane k at [32k+31:32k]
//   ghr_o                        global history

interface branch_predictor_nway_if #(
    parameter int unsigned LANES = 2,
    parameter int unsigned HBITS = 10
);
    logic                  we_i;
    logic [31:0]           pc_i;
    logic                  update_i;
    logic [31:0]           update_pc_i;
    logic [31:0]           update_tgt_i;
    logic                  update_taken_i;
    logic                  update_is_br_i;
    logic                  ready_o;
    logic [LANES-1:0]      hit_o;
    logic [LANES-1:0]      pred_o;
    logic [32*LANES-1:0]   tgt_o;
    logic [HBITS-1:0]      ghr_o;

    modport master (
        output we_i, pc_i, update_i, update_pc_i, update_tgt_i, update_taken_i, update_is_br_i,
        input  ready_o, hit_o, pred_o, tgt_o, ghr_o
    );

    modport slave (
        input  we_i, pc_i, update_i, update_pc_i, update_tgt_i, update_taken_i, update_is_br_i,
        output ready_o, hit_o, pred_o, tgt_o, ghr_o
    );
endinterface

// File: rtl/bp_sat_counter.sv
// bp_sat_counter
//   Next value of a CBITS-wide saturating counter; never wraps.
// Ports:
//   cnt_i         current counter value
//   taken_i       1 = count up, 0 = count down
//   force_zero_i  overrides direction, result is 0
//   cnt_o         next counter value

module bp_sat_counter #(
    parameter int unsigned CBITS = 2
) (
    input  logic [CBITS-1:0] cnt_i,
    input  logic             taken_i,
    input  logic             force_zero_i,
    output logic [CBITS-1:0] cnt_o
);
    localparam logic [CBITS:0] One = {{CBITS{1'b0}}, 1'b1};

    logic [CBITS:0] w_ext;
    logic [CBITS:0] w_inc;
    logic [CBITS:0] w_dec;

    // One spare bit: carry out of w_inc / borrow out of w_dec marks saturation.
    assign w_ext = {1'b0, cnt_i};
    assign w_inc = w_ext + One;
    assign w_dec = w_ext - One;

    always_comb begin
        cnt_o = cnt_i;
        if (force_zero_i) begin
            cnt_o = '0;
        end else if (taken_i) begin
            if (!w_inc[CBITS]) cnt_o = w_inc[CBITS-1:0];
        end else begin
            if (!w_dec[CBITS]) cnt_o = w_dec[CBITS-1:0];
        end
    end
endmodule

// File: rtl/branch_predictor_nway.sv
// branch_predictor_nway
//   LANES-wide bimodal predictor + valid-tagged BTB with global history and a
//   one-entry-per-cycle table-clear sweep after reset. Lookup is 1-cycle: pc_i is
//   registered on we_i, outputs decode from that register and current tables.
//   Optional: GSHARE_HASH_EN xors the history into the PHT index (BTB never hashed).
// Ports:
//   clock_i  clock
//   reset_i  synchronous active-high reset (restarts the clear sweep)
//   bus      branch_predictor_nway_if.slave (fetch, update, prediction outputs)

module branch_predictor_nway
    import branch_predictor_nway_pkg::*;
#(
    parameter int unsigned ABITS = 10,
    parameter int unsigned LANES = 2,
    parameter int unsigned CBITS = 2,
    parameter int unsigned HBITS = 10
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    branch_predictor_nway_if.slave bus
);
    localparam int unsigned    Entries = 2 ** ABITS;
    localparam int unsigned    TagW    = 30 - ABITS;
    localparam logic [CBITS-1:0] CntInit = CBITS'(counter_init(CBITS));

    bp_state_e          r_state;
    bp_state_e          w_state_d;
    logic [ABITS-1:0]   r_clr_idx;
    logic [ABITS-1:0]   w_clr_idx_d;
    logic [31:0]        r_pc;
    logic [HBITS-1:0]   r_ghr;

    logic [CBITS-1:0]   r_cnt   [Entries];
    logic               r_valid [Entries];
    logic [TagW-1:0]    r_tag   [Entries];
    logic [29:0]        r_tgt   [Entries];

    logic               w_ready;
    logic [ABITS-1:0]   w_hash;
    logic [TagW-1:0]    w_tag;
    logic               w_upd_en;
    logic [ABITS-1:0]   w_upd_bidx;
    logic [ABITS-1:0]   w_upd_pidx;
    logic [CBITS-1:0]   w_cnt_new;
    logic               w_unused;

    assign w_ready = (r_state == StReady);

`ifdef GSHARE_HASH_EN
    assign w_hash = ABITS'(r_ghr);
`else
    assign w_hash = '0;
`endif

    // ---------------- FSM ----------------
    always_comb begin
        w_state_d   = r_state;
        w_clr_idx_d = r_clr_idx;
        case (r_state)
            StClear: begin
                w_clr_idx_d = r_clr_idx + 1'b1;
                if (r_clr_idx == '1) w_state_d = StReady;
            end
            StReady: ;
            default: w_state_d = StClear;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state   <= StClear;
            r_clr_idx <= '0;
            r_pc      <= '0;
            r_ghr     <= '0;
        end else begin
            r_state   <= w_state_d;
            r_clr_idx <= w_clr_idx_d;
            if (w_ready && bus.we_i) r_pc <= bus.pc_i;
            if (w_upd_en && bus.update_is_br_i) begin
                r_ghr <= (r_ghr << 1) | HBITS'(bus.update_taken_i);
            end
        end
    end

    // ---------------- Update path ----------------
    assign w_upd_en   = bus.update_i && w_ready;
    assign w_upd_bidx = bus.update_pc_i[`IDX_RANGE(ABITS)];
    // Write index uses history before this update shifts it in.
    assign w_upd_pidx = w_upd_bidx ^ w_hash;

    bp_sat_counter #(
        .CBITS (CBITS)
    ) u_sat_counter (
        .cnt_i        (r_cnt[w_upd_pidx]),
        .taken_i      (bus.update_taken_i),
        .force_zero_i (!bus.update_is_br_i),
        .cnt_o        (w_cnt_new)
    );

    // Tables carry no reset; the sweep initialises counters and valid bits.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            if (r_state == StClear) begin
                r_cnt[r_clr_idx]   <= CntInit;
                r_valid[r_clr_idx] <= 1'b0;
            end else if (bus.update_i) begin
                r_cnt[w_upd_pidx] <= w_cnt_new;
                if (!bus.update_is_br_i) begin
                    r_valid[w_upd_bidx] <= 1'b0;
                end else if (bus.update_taken_i) begin
                    r_valid[w_upd_bidx] <= 1'b1;
                    r_tag[w_upd_bidx]   <= bus.update_pc_i[`TAG_RANGE(ABITS)];
                    r_tgt[w_upd_bidx]   <= bus.update_tgt_i[31:2];
                end
            end
        end
    end

    // ---------------- Lookup ----------------
    // All lanes compare against the fetch PC's tag, even after the index wraps.
    assign w_tag = r_pc[`TAG_RANGE(ABITS)];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [ABITS-1:0] w_lidx;
        logic [ABITS-1:0] w_pidx;

        assign w_lidx = r_pc[`IDX_RANGE(ABITS)] + ABITS'(k);
        assign w_pidx = w_lidx ^ w_hash;

        assign bus.hit_o[k]  = w_ready && r_valid[w_lidx] && (r_tag[w_lidx] == w_tag);
        assign bus.pred_o[k] = bus.hit_o[k] && r_cnt[w_pidx][CBITS-1];
        assign bus.tgt_o[32*k +: 32] = w_ready ? {r_tgt[w_lidx], 2'b00} : 32'h0;
    end

    assign bus.ready_o = w_ready;
    assign bus.ghr_o   = r_ghr;

    assign w_unused = ^{r_pc[1:0], bus.update_pc_i[1:0], bus.update_tgt_i[1:0]};
endmodule

// File: tb/tb_branch_predictor_nway.sv
// tb_branch_predictor_nway
//   Directed vectors with hand-computed expectations for branch_predictor_nway
//   configured ABITS=4, LANES=2, CBITS=2, HBITS=4.

module tb_branch_predictor_nway;
    import branch_predictor_nway_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miscmp;
    int   cyc;

    branch_predictor_nway_if #(.LANES(2), .HBITS(4)) bus ();

    branch_predictor_nway #(
        .ABITS (4),
        .LANES (2),
        .CBITS (2),
        .HBITS (4)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        bus.we_i = 1'b1;
        bus.pc_i = pc;
        tick();
        bus.we_i = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                       input logic is_br);
        bus.update_pc_i    = pc;
        bus.update_tgt_i   = tgt;
        bus.update_taken_i = taken;
        bus.update_is_br_i = is_br;
        bus.update_i       = 1'b1;
        tick();
        bus.update_i       = 1'b0;
    endtask

    // Counts samples with ready_o low, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.ready_o && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        logic [63:0] t;
        logic [1:0]  exp_pred;
        n_vec    = 0;
        n_miscmp = 0;
        rst                = 1'b1;
        bus.we_i           = 1'b0;
        bus.pc_i           = '0;
        bus.update_i       = 1'b0;
        bus.update_pc_i    = '0;
        bus.update_tgt_i   = '0;
        bus.update_taken_i = 1'b0;
        bus.update_is_br_i = 1'b0;

        // 1: single-cycle reset, 16-cycle sweep
        tick();
        rst = 1'b0;
        check_val("clr_hit", 64'(bus.hit_o), 64'h0);
        check_val("clr_tgt", bus.tgt_o, 64'h0);
        check_val("rst_ghr", 64'(bus.ghr_o), 64'h0);
        wait_ready(cyc);
        check_val("sweep_len", 64'(cyc), 64'd16);
        check_val("ready_hit", 64'(bus.hit_o), 64'h0);

        // 2: train 0x40 -> 0x100 taken twice
        upd(32'h40, 32'h100, 1'b1, 1'b1);
        upd(32'h40, 32'h100, 1'b1, 1'b1);
        lookup(32'h40);
        t = bus.tgt_o;
        check_val("t2_hit", 64'(bus.hit_o), 64'h1);
        check_val("t2_pred", 64'(bus.pred_o), 64'h1);
        check_val("t2_tgt0", 64'(t[31:0]), 64'h100);
        check_val("t2_ghr", 64'(bus.ghr_o), 64'h3);

        // 4: saturation then decay
        for (int i = 0; i < 3; i++) upd(32'h40, 32'h100, 1'b1, 1'b1);
        lookup(32'h40);
        check_val("t4_sat_pred", 64'(bus.pred_o), 64'h1);
        upd(32'h40, 32'h0, 1'b0, 1'b1);
        lookup(32'h40);
        check_val("t4_nt1_pred", 64'(bus.pred_o), 64'h1);
        check_val("t4_nt1_hit", 64'(bus.hit_o), 64'h1);
        upd(32'h40, 32'h0, 1'b0, 1'b1);
        lookup(32'h40);
        check_val("t4_nt2_pred", 64'(bus.pred_o), 64'h0);
        check_val("t4_ghr", 64'(bus.ghr_o), 64'hC);

        // 5: not-a-branch invalidates, history untouched
        upd(32'h40, 32'h0, 1'b0, 1'b0);
        lookup(32'h40);
        check_val("t5_hit", 64'(bus.hit_o), 64'h0);
        check_val("t5_pred", 64'(bus.pred_o), 64'h0);
        check_val("t5_ghr", 64'(bus.ghr_o), 64'hC);

        // 3: lane wrap 15 -> 0 with fetch-PC tag (0)
        lookup(32'h3C);
        check_val("t3_pre_hit", 64'(bus.hit_o), 64'h0);
        upd(32'h0, 32'h200, 1'b1, 1'b1);
        lookup(32'h3C);
        t = bus.tgt_o;
        check_val("t3_hit", 64'(bus.hit_o), 64'h2);
        check_val("t3_tgt1", 64'(t[63:32]), 64'h200);
        check_val("t3_pred", 64'(bus.pred_o), 64'h0);
        check_val("t3_ghr", 64'(bus.ghr_o), 64'h9);

        // 6: reset mid-sweep restarts it; updates ignored while clearing
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.update_pc_i    = 32'h40;
        bus.update_tgt_i   = 32'h100;
        bus.update_taken_i = 1'b1;
        bus.update_is_br_i = 1'b1;
        bus.update_i       = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check_val("t6_midsweep_rdy", 64'(bus.ready_o), 64'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready(cyc);
        bus.update_i = 1'b0;
        check_val("t6_sweep_len", 64'(cyc), 64'd16);
        check_val("t6_ghr", 64'(bus.ghr_o), 64'h0);
        lookup(32'h40);
        check_val("t6_hit", 64'(bus.hit_o), 64'h0);

        // History effect on PHT read: ghr=1 after one taken update at idx 0
        upd(32'h40, 32'h100, 1'b1, 1'b1);
        lookup(32'h40);
`ifdef GSHARE_HASH_EN
        exp_pred = 2'b00;
`else
        exp_pred = 2'b01;
`endif
        check_val("t6b_hit", 64'(bus.hit_o), 64'h1);
        check_val("t6b_pred", 64'(bus.pred_o), 64'(exp_pred));
        check_val("t6b_ghr", 64'(bus.ghr_o), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
